// File: rtl/dcache_direct_mapped.sv
// dcache_direct_mapped
// Direct-mapped, write-through, no-write-allocate data cache for the memory
// stage. Each line holds four 32-bit words. A load hit answers combinationally.
// A load miss refills the whole line over the memory handshake. A store is
// always written through, and it updates the cached copy only when it hits.
//
// Optional feature: define DCACHE_STATS_EN to add the load_count and
// miss_count performance counters.
module dcache_direct_mapped #(
    parameter int LINES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] data,
    input  logic        is_load,
    input  logic        is_store,
    output logic [31:0] out,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] load_count,
    output logic [31:0] miss_count
`endif
);

    localparam int IB = $clog2(LINES);
    localparam int TW = 32 - IB - 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REFILL = 2'd1;
    localparam logic [1:0] ST_WRITE  = 2'd2;

    // Request-side address fields
    logic [1:0]    req_offset;
    logic [IB-1:0] req_index;
    logic [TW-1:0] req_tag;

    // Fields of the address held in the memory request register; these steer
    // refill and write-through updates so they do not depend on the pipeline
    logic [1:0]    fill_offset;
    logic [IB-1:0] fill_index;
    logic [TW-1:0] fill_tag;

    // Line storage
    logic [LINES-1:0] valid_vec;
    logic [TW-1:0]    tag_mem  [LINES];
    logic [31:0]      data_mem [LINES*4];

    // Control state
    logic [1:0]  state_reg, state_next;
    logic [1:0]  beat_reg;
    logic        store_done_reg;
    logic        mem_req_reg;
    logic        mem_we_reg;
    logic [31:0] mem_addr_reg;
    logic [31:0] mem_wdata_reg;

    logic hit;
    logic wr_hit;
    logic ack_seen;
    logic start_refill;
    logic start_write;
    logic refill_beat;
    logic fill_done;
    logic store_update;

    // Word accesses only; the byte-lane bits carry no information here
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[1:0];

    assign req_offset  = addr[3:2];
    assign req_index   = addr[IB+3:4];
    assign req_tag     = addr[31:IB+4];
    assign fill_offset = mem_addr_reg[3:2];
    assign fill_index  = mem_addr_reg[IB+3:4];
    assign fill_tag    = mem_addr_reg[31:IB+4];

    assign hit    = valid_vec[req_index]  && (tag_mem[req_index]  == req_tag);
    assign wr_hit = valid_vec[fill_index] && (tag_mem[fill_index] == fill_tag);

    // An ack only counts while a request is actually outstanding
    assign ack_seen     = mem_ack && mem_req_reg;
    assign refill_beat  = (state_reg == ST_REFILL) && ack_seen;
    assign fill_done    = refill_beat && (beat_reg == 2'd3);
    assign store_update = (state_reg == ST_WRITE) && ack_seen && wr_hit;

    // Next-state decode and the combinational stall to the pipeline
    always_comb begin
        state_next   = state_reg;
        stall        = 1'b0;
        start_refill = 1'b0;
        start_write  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (is_store) begin
                    // A finished store is released once; otherwise write it
                    if (!store_done_reg) begin
                        stall       = 1'b1;
                        start_write = 1'b1;
                        state_next  = ST_WRITE;
                    end
                end else if (is_load && !hit) begin
                    stall        = 1'b1;
                    start_refill = 1'b1;
                    state_next   = ST_REFILL;
                end
            end
            ST_REFILL: begin
                stall = 1'b1;
                if (fill_done) begin
                    state_next = ST_IDLE;
                end
            end
            ST_WRITE: begin
                stall = 1'b1;
                if (ack_seen) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // FSM, beat counter and the registered memory-bus request
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            beat_reg       <= 2'd0;
            store_done_reg <= 1'b0;
            mem_req_reg    <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= 32'd0;
            mem_wdata_reg  <= 32'd0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    // store_done only has to survive the single release cycle
                    store_done_reg <= 1'b0;
                    if (start_write) begin
                        mem_req_reg   <= 1'b1;
                        mem_we_reg    <= 1'b1;
                        mem_addr_reg  <= {addr[31:2], 2'b00};
                        mem_wdata_reg <= data;
                    end else if (start_refill) begin
                        mem_req_reg  <= 1'b1;
                        mem_we_reg   <= 1'b0;
                        mem_addr_reg <= {addr[31:4], 4'b0000};
                        beat_reg     <= 2'd0;
                    end
                end
                ST_REFILL: begin
                    if (ack_seen) begin
                        beat_reg <= beat_reg + 2'd1;
                        if (beat_reg == 2'd3) begin
                            mem_req_reg <= 1'b0;
                        end else begin
                            mem_addr_reg[3:2] <= beat_reg + 2'd1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (ack_seen) begin
                        mem_req_reg    <= 1'b0;
                        store_done_reg <= 1'b1;
                    end
                end
                default: begin
                    mem_req_reg <= 1'b0;
                end
            endcase
        end
    end

    // Per-line valid bits: invalidated when a refill starts, set on its last beat
    genvar gi;
    generate
        for (gi = 0; gi < LINES; gi++) begin : g_line
            logic valid_bit_reg;

            // Line valid flag
            always_ff @(posedge clock) begin
                if (reset) begin
                    valid_bit_reg <= 1'b0;
                end else if (start_refill && (req_index == IB'(gi))) begin
                    valid_bit_reg <= 1'b0;
                end else if (fill_done && (fill_index == IB'(gi))) begin
                    valid_bit_reg <= 1'b1;
                end
            end

            assign valid_vec[gi] = valid_bit_reg;
        end
    endgenerate

    // Tag array: written when a line refill completes
    always_ff @(posedge clock) begin
        if (fill_done) begin
            tag_mem[fill_index] <= fill_tag;
        end
    end

    // Data array: refill beats and write-through updates on a store hit
    always_ff @(posedge clock) begin
        if (refill_beat) begin
            data_mem[{fill_index, beat_reg}] <= mem_rdata;
        end else if (store_update) begin
            data_mem[{fill_index, fill_offset}] <= mem_wdata_reg;
        end
    end

    assign out       = (is_load && hit) ? data_mem[{req_index, req_offset}] : 32'd0;
    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;

`ifdef DCACHE_STATS_EN
    logic [31:0] load_count_reg;
    logic [31:0] miss_count_reg;

    // Counters for completed loads and line refills, both wrapping
    always_ff @(posedge clock) begin
        if (reset) begin
            load_count_reg <= 32'd0;
            miss_count_reg <= 32'd0;
        end else begin
            if ((state_reg == ST_IDLE) && is_load && !stall) begin
                load_count_reg <= load_count_reg + 32'd1;
            end
            if (start_refill) begin
                miss_count_reg <= miss_count_reg + 32'd1;
            end
        end
    end

    assign load_count = load_count_reg;
    assign miss_count = miss_count_reg;
`endif

endmodule

// File: doc/dcache_direct_mapped.md
# dcache_direct_mapped

Direct-mapped, write-through, no-write-allocate data cache serving the memory stage of the 32-bit RISC-V pipeline. It receives load/store requests and raises `stall` until each request can complete. Line refills and store write-through go to backing memory over a req/ack handshake. `stall` freezes the memory-stage output registers; the block sits between the memory stage and the shared memory bus.

## Interface
- `LINES`, 16: number of cache lines; power of two, ≥2; each line holds 4 words.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `addr`  in  32  byte address from the ALU result; `addr[1:0]` ignored (word access only).
- `data`  in  32  store data.
- `is_load`  in  1  load request.
- `is_store`  in  1  store request.
- `out`  out  32  load data.
- `stall`  out  1  request not complete; combinational.
- `mem_req`  out  1  memory request valid.
- `mem_we`  out  1  1 = write, 0 = read.
- `mem_addr`  out  32  word-aligned memory address.
- `mem_wdata`  out  32  write data.
- `mem_ack`  in  1  memory completes the current request this cycle.
- `mem_rdata`  in  32  read data, valid while `mem_ack` = 1.

## Operation
- Address split, with IB = log2(LINES):
  - offset = `addr[3:2]`
  - index = `addr[IB+3:4]`
  - tag = `addr[31:IB+4]`
- Per-line storage: valid bit, tag, and 4 data words.
- hit = valid[index] & (tag match).
- States:
  - IDLE
  - REFILL (4 read beats; beat counter 0–3)
  - WRITE (one write beat)
- IDLE behaviour:
  - `is_store`: raise `stall`, go to WRITE. A store takes priority if `is_load` is also high.
  - Else `is_load` & !hit: raise `stall`, go to REFILL with beat = 0.
  - Else `is_load` & hit: `stall` = 0; `out` = cached word.
- REFILL:
  - Drive `mem_req` = 1, `mem_we` = 0, `mem_addr` = {tag, index, beat, 2'b00}.
  - On each `mem_ack`: write `mem_rdata` into word[beat], then beat++.
  - On the beat-3 ack: set valid and tag, return to IDLE. The retried load then hits.
- WRITE:
  - Drive `mem_req` = 1, `mem_we` = 1, `mem_addr` = {addr[31:2], 2'b00}, `mem_wdata` = `data`.
  - On `mem_ack`: if hit, update the cached word. Set `store_done`, return to IDLE.
  - A miss does not allocate.
- `store_done` handling:
  - In IDLE with `is_store` & `store_done` = 1: `stall` = 0, and `store_done` clears at the edge.
  - If the pipeline is held by another stall and the same store is still presented, it is written again. This repeat write is idempotent and accepted.
- `stall` is high in REFILL and WRITE regardless of inputs.
- `out` = cached word when hit, else 0.
- `mem_ack` is ignored while `mem_req` = 0.

## Timing
- Reset values:
  - state = IDLE, all valid bits = 0, beat = 0, `store_done` = 0.
  - `mem_req` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0.
  - `out` = 0 and `stall` = 0 when no request is presented.
- Load hit: zero added latency; `stall` stays low in the same cycle.
- Load miss: `mem_req` rises the cycle after the miss is detected. Once the last ack is seen, `stall` falls 1 cycle later with the hit data on `out`.
- Store: `stall` is high for (ack latency + 2) cycles minimum.
- `mem_addr`, `mem_we` and `mem_wdata` are registered and stable while `mem_req` is high. `mem_req` stays high until acked.
- Back-to-back beats: `mem_req` stays high across beats, and `mem_addr` advances on the edge after each ack.
- Reset mid-REFILL or mid-WRITE:
  - The transaction is abandoned and `mem_req` drops on the next edge.
  - A partially filled line stays invalid.
- Load to a conflicting index evicts the old line; clean eviction needs no writeback.

## Configuration
- `DCACHE_STATS_EN` defined:
  - Adds outputs `load_count` (out, 32) and `miss_count` (out, 32), both reset to 0.
  - `load_count` increments on each cycle with `is_load`, state IDLE and `stall` = 0.
  - `miss_count` increments on each IDLE→REFILL transition.
  - Both counters wrap at 2^32.
- Undefined: neither port nor counter exists; all other behaviour is identical.

## Test plan
- Cold miss:
  - Stimulus: after reset, `is_load`, `addr` = 0x100; memory acks 2 cycles after each req with 0xA0, 0xA1, 0xA2, 0xA3.
  - Response: `mem_addr` sequence 0x100/0x104/0x108/0x10C; `stall` falls once the line is complete, with `out` = 0xA0.
- Hit:
  - Stimulus: then load 0x10C.
  - Response: `stall` = 0 in the same cycle, `out` = 0xA3, no `mem_req`.
- Store hit:
  - Stimulus: store 0xDEADBEEF to 0x108.
  - Response: one write with `mem_we` = 1, `mem_addr` = 0x108; `stall` is released one cycle after the ack. A following load of 0x108 hits with 0xDEADBEEF.
- No-allocate:
  - Stimulus: store to 0x2000, then load 0x2000.
  - Response: the load misses and refills from 0x2000.
- Conflict (`LINES` = 16):
  - Stimulus: load 0x100, load 0x500, load 0x100.
  - Response: three refills. With `DCACHE_STATS_EN`: `miss_count` = 3, `load_count` = 3.
- Reset mid-refill:
  - Stimulus: assert `reset` after the beat-1 ack of the 0x100 refill.
  - Response: `mem_req` = 0 on the next edge; a subsequent load of 0x100 misses and refills all 4 beats.
